// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and constants for the hazard sequencer
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, LU_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int LU_W = 4;
  localparam int WAIT_W = 10;
endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// pipeline_hazard_ctrl_hazard_detect: combinational load-use hazard detection on register fields
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       lu_hazard
);
  assign lu_hazard = mem_read && rd != REG_ZERO && (rd == rs || (uses_rt && rd == rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, multi-cycle memory and taken branches
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             ID_EXE_mem_read,
  input  logic [4:0]       ID_EXE_rd,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             IF_ID_uses_rt,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_exe_write_en,
  output logic             exe_mem_write_en,
  output logic             mem_wb_write_en,
  output logic             id_exe_bubble,
  output logic             flush_front,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_mem_timeout
);
  state_t state, state_nx;
  logic [LU_W-1:0] lu_cnt, lu_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic lu_hazard, mem_busy, br, front_stall;
  pipeline_hazard_ctrl_hazard_detect u_hd (
    .mem_read (ID_EXE_mem_read),
    .rd       (ID_EXE_rd),
    .rs       (IF_ID_rs),
    .rt       (IF_ID_rt),
    .uses_rt  (IF_ID_uses_rt),
    .lu_hazard(lu_hazard)
  );
  // Gating by arst_n makes every output fall back to RUN values the instant reset asserts.
  assign mem_busy = arst_n && dmem_req && !dmem_ready;
  assign br = arst_n && !mem_busy && branch_taken;
  assign front_stall = arst_n && !mem_busy && !br && (lu_hazard || state == LU_STALL);
  assign pc_write_en = !mem_busy && !front_stall;
  assign if_id_write_en = pc_write_en;
  assign id_exe_write_en = !mem_busy;
  assign exe_mem_write_en = !mem_busy;
  assign mem_wb_write_en = !mem_busy;
  assign id_exe_bubble = front_stall;
  assign flush_front = br;
  always_comb begin
    state_nx = RUN;
    lu_nx = '0;
    wait_nx = '0;
    if (mem_busy) begin
      state_nx = MEM_WAIT;
      wait_nx = state != MEM_WAIT ? WAIT_W'(1) :
                wait_cnt == WAIT_W'(MEM_TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
    end else if (!br) begin
      if (state == LU_STALL) begin
        lu_nx = lu_cnt - 1'b1;
        state_nx = lu_cnt == LU_W'(1) ? RUN : LU_STALL;
      end else if (lu_hazard && LOAD_STALL_CYCLES > 1) begin
        state_nx = LU_STALL;
        lu_nx = LU_W'(LOAD_STALL_CYCLES - 1);
      end
    end
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RUN;
      lu_cnt <= '0;
      wait_cnt <= '0;
      stall_cnt <= '0;
      err_mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      lu_cnt <= lu_nx;
      wait_cnt <= wait_nx;
      if (!pc_write_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (state == MEM_WAIT && mem_busy && wait_cnt == WAIT_W'(MEM_TIMEOUT)) err_mem_timeout <= 1'b1;
    end
  end
endmodule
